// File: rtl/iiitb_cps_pkg.sv
// Shared types and constants for the parking-system exit gate.
// Latency: none (declarations only).
// Backpressure: none.
package iiitb_cps_pkg;

  // Exit gate FSM encodings.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_REJECT  = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PASSING = 3'd4
  } state_t;

  // Active-low gfedcba glyphs.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Both token halves must equal their expected values.
  function automatic logic token_match(input logic [1:0] t1, input logic [1:0] t2,
                                       input logic [1:0] exp1, input logic [1:0] exp2);
    return (t1 == exp1) && (t2 == exp2);
  endfunction

endpackage

// File: rtl/iiitb_cps_exit_gate_if.sv
// Exit gate signal bundle: sensors, token and car_entered in; barrier, LEDs, displays out.
// Latency: none (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface iiitb_cps_exit_gate_if #(
  parameter int CNT_W = 4
);
  logic             car_entered;
  logic             sensor_exit_req;
  logic             sensor_exit_clear;
  logic [1:0]       token_1;
  logic [1:0]       token_2;
  logic             barrier_open;
  logic             GREEN_LED;
  logic             RED_LED;
  logic             full;
  logic [CNT_W-1:0] free_slots;
  logic [6:0]       HEX_1;
  logic [6:0]       HEX_2;

  modport master (
    output car_entered, sensor_exit_req, sensor_exit_clear, token_1, token_2,
    input  barrier_open, GREEN_LED, RED_LED, full, free_slots, HEX_1, HEX_2
  );

  modport slave (
    input  car_entered, sensor_exit_req, sensor_exit_clear, token_1, token_2,
    output barrier_open, GREEN_LED, RED_LED, full, free_slots, HEX_1, HEX_2
  );
endinterface

// File: rtl/iiitb_cps_sevenseg.sv
// Decimal digit to active-low gfedcba pattern; values above 9 are blank.
// Latency: combinational.
// Backpressure: none.
module iiitb_cps_sevenseg
  import iiitb_cps_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Glyph lookup.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/iiitb_cps_exit_gate.sv
// Exit barrier controller: occupancy tracking, token check, barrier/LED/7-seg drive.
// Latency: outputs are a Moore decode of registered state; token checked TOKEN_WAIT cycles after request.
// Backpressure: none; car_entered dropped when full. Optional barrier timeout: CPS_EXIT_TIMEOUT_EN.
module iiitb_cps_exit_gate
  import iiitb_cps_pkg::*;
#(
  parameter int         CAPACITY    = 8,
  parameter int         CNT_W       = 4,
  parameter int         TOKEN_WAIT  = 4,
  parameter int         OPEN_CYCLES = 16,
  parameter logic [1:0] TOKEN_1     = 2'b11,
  parameter logic [1:0] TOKEN_2     = 2'b00
) (
  input logic             clk,
  input logic             reset_n,
  iiitb_cps_exit_gate_if.slave bus
);

  localparam int               WAIT_W    = (TOKEN_WAIT > 1) ? $clog2(TOKEN_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TOKEN_WAIT - 1);
  localparam logic [CNT_W-1:0]  CAP_V     = CNT_W'(CAPACITY);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  occ_nxt;
  logic [CNT_W-1:0]  free_slots;
  logic [WAIT_W-1:0] wait_cnt;
  logic              blink;
  logic              full;
  logic              tok_ok;
  logic              inc;
  logic              dec;
  logic              timeout;

  assign tok_ok     = token_match(bus.token_1, bus.token_2, TOKEN_1, TOKEN_2);
  assign full       = (occupancy == CAP_V);
  assign free_slots = CAP_V - occupancy;

`ifdef CPS_EXIT_TIMEOUT_EN
  localparam int                OPEN_W    = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [OPEN_W-1:0] OPEN_LAST = OPEN_W'(OPEN_CYCLES - 1);

  logic [OPEN_W-1:0] open_cnt;

  // Count cycles spent in OPEN; cleared on any other state or on leaving OPEN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      open_cnt <= '0;
    end else if (state == ST_OPEN && state_nxt == ST_OPEN) begin
      open_cnt <= open_cnt + 1'b1;
    end else begin
      open_cnt <= '0;
    end
  end

  assign timeout = (open_cnt == OPEN_LAST);
`else
  // Without the timeout the barrier waits for the car indefinitely.
  assign timeout = 1'b0;
  if (OPEN_CYCLES < 1) begin : g_open_cycles_unused
  end
`endif

  // State, occupancy, token wait counter and reject blink flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      occupancy <= '0;
      wait_cnt  <= '0;
      blink     <= 1'b0;
    end else begin
      state     <= state_nxt;
      occupancy <= occ_nxt;
      wait_cnt  <= (state == ST_CHECK && state_nxt == ST_CHECK) ? wait_cnt + 1'b1 : '0;
      blink     <= (state == ST_REJECT) ? ~blink : 1'b0;
    end
  end

  // Next-state logic; dec flags the single decrement when a car leaves PASSING.
  always_comb begin
    state_nxt = state;
    dec       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.sensor_exit_req && occupancy != '0) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!bus.sensor_exit_req)   state_nxt = ST_IDLE;
        else if (wait_cnt == WAIT_LAST) state_nxt = tok_ok ? ST_OPEN : ST_REJECT;
      end
      ST_REJECT: begin
        if (tok_ok)                    state_nxt = ST_OPEN;
        else if (!bus.sensor_exit_req) state_nxt = ST_IDLE;
      end
      ST_OPEN: begin
        if (bus.sensor_exit_clear) state_nxt = ST_PASSING;
        else if (timeout)          state_nxt = ST_IDLE;
      end
      ST_PASSING: begin
        if (!bus.sensor_exit_clear) begin
          state_nxt = ST_IDLE;
          dec       = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Occupancy update; an entry is allowed at full when a car leaves in the same cycle.
  always_comb begin
    inc     = bus.car_entered && (!full || dec);
    occ_nxt = occupancy;
    case ({inc, dec})
      2'b10:   occ_nxt = occupancy + 1'b1;
      2'b01:   occ_nxt = occupancy - 1'b1;
      default: occ_nxt = occupancy;
    endcase
  end

  // Moore output decode.
  always_comb begin
    bus.barrier_open = 1'b0;
    bus.GREEN_LED    = 1'b0;
    bus.RED_LED      = 1'b0;
    bus.HEX_1        = SEG_BLANK;
    case (state)
      ST_CHECK: begin
        bus.RED_LED = 1'b1;
        bus.HEX_1   = SEG_C;
      end
      ST_REJECT: begin
        bus.RED_LED = blink;
        bus.HEX_1   = SEG_E;
      end
      ST_OPEN, ST_PASSING: begin
        bus.barrier_open = 1'b1;
        bus.GREEN_LED    = 1'b1;
        bus.HEX_1        = SEG_O;
      end
      default: bus.HEX_1 = SEG_BLANK;
    endcase
  end

  assign bus.full       = full;
  assign bus.free_slots = free_slots;

  iiitb_cps_sevenseg u_hex2 (
    .digit (4'(free_slots)),
    .seg   (bus.HEX_2)
  );

endmodule

// File: tb/tb_iiitb_cps_exit_gate.sv
// Directed bench for the exit gate; expected output snapshots are queued per step.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none.
module tb_iiitb_cps_exit_gate;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  iiitb_cps_exit_gate_if #(.CNT_W(4)) bus ();

  iiitb_cps_exit_gate dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_O     = 7'b0100011;
  localparam int         CAP     = 8;

  typedef struct packed {
    logic       barrier;
    logic       green;
    logic       red;
    logic       full;
    logic [3:0] free;
    logic [6:0] hex1;
    logic [6:0] hex2;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  e;
  } sb_t;

  sb_t sbq[$];
  int  checks   = 0;
  int  failures = 0;
  int  occ      = 0;

  function automatic logic [6:0] digit(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic obs_t mk(input logic bar, input logic grn, input logic red,
                              input logic [6:0] h1, input int o);
    obs_t r;
    r.barrier = bar;
    r.green   = grn;
    r.red     = red;
    r.full    = (o == CAP);
    r.free    = 4'(CAP - o);
    r.hex1    = h1;
    r.hex2    = digit(CAP - o);
    return r;
  endfunction

  function automatic obs_t idle_e();
    return mk(1'b0, 1'b0, 1'b0, G_BLANK, occ);
  endfunction
  function automatic obs_t check_e();
    return mk(1'b0, 1'b0, 1'b1, G_C, occ);
  endfunction
  function automatic obs_t rej_e(input logic r);
    return mk(1'b0, 1'b0, r, G_E, occ);
  endfunction
  function automatic obs_t open_e();
    return mk(1'b1, 1'b1, 1'b0, G_O, occ);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out();
    sb_t  s;
    obs_t o;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=nothing queued expected=one entry");
    end else begin
      s = sbq.pop_front();
      o = {bus.barrier_open, bus.GREEN_LED, bus.RED_LED, bus.full,
           bus.free_slots, bus.HEX_1, bus.HEX_2};
      assert (o === s.e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", s.tag, o, s.e);
      end
    end
  endtask

  // Queue the expectation when the stimulus is applied, then pop it after the edge.
  task automatic step(input string tag, input obs_t e);
    sb_t s;
    s.tag = tag;
    s.e   = e;
    sbq.push_back(s);
    tick();
    check_out();
  endtask

  task automatic run_check(input string tag);
    for (int k = 0; k < 4; k++) step($sformatf("%s_check%0d", tag, k), check_e());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n               = 1'b0;
    bus.car_entered       = 1'b0;
    bus.sensor_exit_req   = 1'b0;
    bus.sensor_exit_clear = 1'b0;
    bus.token_1           = 2'b00;
    bus.token_2           = 2'b00;

    occ = 0;
    step("reset", idle_e());
    reset_n = 1'b1;

    // Three cars in.
    for (int i = 0; i < 3; i++) begin
      bus.car_entered = 1'b1;
      occ++;
      step($sformatf("enter%0d", i), idle_e());
    end
    bus.car_entered = 1'b0;
    step("after_enter", idle_e());
    checks++;
    assert (bus.HEX_2 === 7'b0010010) else begin
      failures++;
      $error("FAIL hex2_five observed=%b expected=0010010", bus.HEX_2);
    end

    // Valid token: 4 cycles in CHECK, then OPEN, pass through.
    bus.token_1 = 2'b11; bus.token_2 = 2'b00; bus.sensor_exit_req = 1'b1;
    run_check("good");
    step("good_open", open_e());
    bus.sensor_exit_req = 1'b0; bus.sensor_exit_clear = 1'b1;
    step("good_passing", open_e());
    bus.sensor_exit_clear = 1'b0; occ--;
    step("good_exit", idle_e());

    // Request dropped during CHECK.
    bus.sensor_exit_req = 1'b1;
    step("drop_check", check_e());
    bus.sensor_exit_req = 1'b0;
    step("drop_idle", idle_e());

    // Wrong token: REJECT with blinking red, then correct token opens.
    bus.token_1 = 2'b01; bus.token_2 = 2'b10; bus.sensor_exit_req = 1'b1;
    run_check("bad");
    step("rej0", rej_e(1'b0));
    step("rej1", rej_e(1'b1));
    step("rej2", rej_e(1'b0));
    bus.token_1 = 2'b11; bus.token_2 = 2'b00;
    step("rej_open", open_e());
    bus.sensor_exit_req = 1'b0; bus.sensor_exit_clear = 1'b1;
    step("rej_passing", open_e());
    bus.sensor_exit_clear = 1'b0; occ--;
    step("rej_exit", idle_e());

    // Fill to capacity; the last pulse is dropped.
    for (int i = 0; i < 8; i++) begin
      bus.car_entered = 1'b1;
      if (occ < CAP) occ++;
      step($sformatf("fill%0d", i), idle_e());
    end
    bus.car_entered = 1'b0;

    // Entry and exit in the same cycle at full.
    bus.sensor_exit_req = 1'b1;
    run_check("sim");
    step("sim_open", open_e());
    bus.sensor_exit_req = 1'b0; bus.sensor_exit_clear = 1'b1;
    step("sim_passing", open_e());
    bus.sensor_exit_clear = 1'b0; bus.car_entered = 1'b1;
    step("sim_exit_enter", idle_e());
    bus.car_entered = 1'b0;

    // Reset while PASSING closes the barrier and clears occupancy.
    bus.sensor_exit_req = 1'b1;
    run_check("rst");
    step("rst_open", open_e());
    bus.sensor_exit_req = 1'b0; bus.sensor_exit_clear = 1'b1;
    step("rst_passing", open_e());
    reset_n = 1'b0; occ = 0;
    step("rst_in_passing", idle_e());
    reset_n = 1'b1; bus.sensor_exit_clear = 1'b0;

    // Request at occupancy 0 is ignored.
    bus.sensor_exit_req = 1'b1;
    for (int i = 0; i < 10; i++) step($sformatf("empty_req%0d", i), idle_e());
    bus.sensor_exit_req = 1'b0;

`ifdef CPS_EXIT_TIMEOUT_EN
    // Barrier times out with no car passing; occupancy unchanged.
    bus.car_entered = 1'b1; occ = 1;
    step("to_enter", idle_e());
    bus.car_entered = 1'b0; bus.sensor_exit_req = 1'b1;
    run_check("to");
    step("to_open", open_e());
    bus.sensor_exit_req = 1'b0;
    for (int i = 1; i < 16; i++) step($sformatf("to_hold%0d", i), open_e());
    step("to_idle", idle_e());
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
